lbp_hist: RTL and testbench

LBP_HIST -- requirements
Module: lbp_hist

---
 rtl/lbp_hist_if.sv | 29 ++
 rtl/lbp_hist.sv | 99 +++++++++
 tb/tb_lbp_hist.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lbp_hist_if.sv
// Upstream LBP result stream and downstream histogram readout of lbp_hist.
// The master side is the producer of results and the consumer of bins.
interface lbp_hist_if #(
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 14
);
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [7:0]        lbp_data;
    logic              finish;
    logic              in_ready;
    logic              hist_valid;
    logic              hist_ready;
    logic [7:0]        hist_bin;
    logic [CNT_W-1:0]  hist_count;
    logic [CNT_W-1:0]  total_count;
    logic              err;
    logic              done;

    modport master (
        output lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
        input  in_ready, hist_valid, hist_bin, hist_count, total_count, err, done
    );

    modport slave (
        input  lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
        output in_ready, hist_valid, hist_bin, hist_count, total_count, err, done
    );
endinterface

// File: rtl/lbp_hist.sv
// 256-bin histogram of LBP codes over the interior of a square image, with a
// clear pass before accumulation and a ready/valid drain of all bins afterwards.
module lbp_hist #(
    parameter int IMG_W = 128,
    parameter int CNT_W = 14
) (
    input logic       clk,
    input logic       reset,
    lbp_hist_if.slave bus
);
    localparam int PW = $clog2(IMG_W);

    typedef enum logic [1:0] {S_CLEAR, S_ACCUM, S_DUMP, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       idx_q, idx_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] bins_q [256];

    logic [PW-1:0]    row, col;
    logic             on_border;
    logic             count_en;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign row       = bus.lbp_addr[2*PW-1:PW];
    assign col       = bus.lbp_addr[PW-1:0];
    assign on_border = (row == '0) || (row == PW'(IMG_W - 1)) ||
                       (col == '0) || (col == PW'(IMG_W - 1));
    assign count_en  = (state_q == S_ACCUM) && bus.lbp_valid && !on_border;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_CLEAR;
            idx_q   <= 8'd0;
            total_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            total_q <= total_d;
            err_q   <= err_d;
        end
    end

    // idx_q is shared: clear pointer in CLEAR, readout pointer in DUMP.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        total_d = count_en ? sat_inc(total_q) : total_q;
        err_d   = err_q | (bus.lbp_valid && (state_q != S_ACCUM));
        case (state_q)
            S_CLEAR: begin
                idx_d = idx_q + 8'd1;
                if (idx_q == 8'hFF) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (bus.finish) begin
                    state_d = S_DUMP;
                    idx_d   = 8'd0;
                end
            end
            S_DUMP: begin
                if (bus.hist_ready) begin
                    if (idx_q == 8'hFF) state_d = S_DONE;
                    else                idx_d   = idx_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_CLEAR;
        endcase
    end

    always_comb begin
        bus.in_ready    = (state_q == S_ACCUM);
        bus.hist_valid  = (state_q == S_DUMP);
        bus.hist_bin    = 8'd0;
        bus.hist_count  = '0;
        bus.total_count = total_q;
        bus.err         = err_q;
        bus.done        = (state_q == S_DONE);
        if (state_q == S_DUMP) begin
            bus.hist_bin   = idx_q;
            bus.hist_count = bins_q[idx_q];
        end
    end

    // Bin storage is data only; CLEAR is what makes it meaningful after reset.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            bins_q[idx_q] <= '0;
        end else if (count_en) begin
            bins_q[bus.lbp_data] <= sat_inc(bins_q[bus.lbp_data]);
        end
    end
endmodule

// File: tb/tb_lbp_hist.sv
// Directed bench for lbp_hist: clear timing, accumulation, border filter,
// drain backpressure, mid-drain reset, early finish and counter saturation.
module tb_lbp_hist;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   got_h [256];
    int   exp_h [256];

    lbp_hist_if #(.ADDR_W(14), .CNT_W(14)) m_if ();
    lbp_hist_if #(.ADDR_W(14), .CNT_W(4))  s_if ();

    lbp_hist #(.IMG_W(128), .CNT_W(14)) dut     (.clk(clk), .reset(reset), .bus(m_if.slave));
    lbp_hist #(.IMG_W(128), .CNT_W(4))  dut_sat (.clk(clk), .reset(reset), .bus(s_if.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        m_if.lbp_valid  = 1'b0;
        m_if.hist_ready = 1'b0;
        s_if.lbp_valid  = 1'b0;
        s_if.hist_ready = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (!m_if.in_ready && n < 1000) begin
            tick();
            n++;
        end
    endtask

    task automatic send(input logic [6:0] row, input logic [6:0] col, input logic [7:0] code);
        m_if.lbp_valid = 1'b1;
        m_if.lbp_addr  = {row, col};
        m_if.lbp_data  = code;
        tick();
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 256; i++) begin
            exp_h[i] = 0;
            got_h[i] = -1;
        end
    endtask

    task automatic drain(input bit rnd);
        int         nacc;
        int         cyc;
        bit         stalled;
        logic [7:0] pb;
        logic [13:0] pc;
        nacc = 0;
        cyc = 0;
        stalled = 1'b0;
        pb = 8'd0;
        pc = 14'd0;
        while (!m_if.done && cyc < 4000) begin
            if (stalled) begin
                chk("stall_bin", 32'(m_if.hist_bin), 32'(pb));
                chk("stall_cnt", 32'(m_if.hist_count), 32'(pc));
            end
            m_if.hist_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = 1'b0;
            if (m_if.hist_valid) begin
                if (m_if.hist_ready) begin
                    chk("order", 32'(m_if.hist_bin), 32'(nacc));
                    if (nacc < 256) got_h[nacc] = int'(m_if.hist_count);
                    nacc++;
                end else begin
                    stalled = 1'b1;
                    pb = m_if.hist_bin;
                    pc = m_if.hist_count;
                end
            end
            tick();
            cyc++;
        end
        m_if.hist_ready = 1'b0;
        chk("drain_n", 32'(nacc), 32'd256);
        chk("done", 32'(m_if.done), 32'd1);
        chk("done_hv", 32'(m_if.hist_valid), 32'd0);
    endtask

    task automatic check_hist();
        for (int i = 0; i < 256; i++) chk($sformatf("bin%0d", i), 32'(got_h[i]), 32'(exp_h[i]));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int sc;
        int cyc;
        m_if.lbp_valid = 1'b0; m_if.lbp_addr = '0; m_if.lbp_data = '0;
        m_if.finish = 1'b0;    m_if.hist_ready = 1'b0;
        s_if.lbp_valid = 1'b0; s_if.lbp_addr = '0; s_if.lbp_data = '0;
        s_if.finish = 1'b0;    s_if.hist_ready = 1'b0;

        // Reset values and clear length
        repeat (2) tick();
        chk("rst_in_ready", 32'(m_if.in_ready), 32'd0);
        chk("rst_hist_valid", 32'(m_if.hist_valid), 32'd0);
        chk("rst_hist_bin", 32'(m_if.hist_bin), 32'd0);
        chk("rst_hist_count", 32'(m_if.hist_count), 32'd0);
        chk("rst_total", 32'(m_if.total_count), 32'd0);
        chk("rst_err", 32'(m_if.err), 32'd0);
        chk("rst_done", 32'(m_if.done), 32'd0);
        reset = 1'b0;
        wait_clear(n);
        chk("clear_len", 32'(n), 32'd256);
        m_if.finish = 1'b1;
        tick();
        chk("dump_start", 32'(m_if.hist_valid), 32'd1);
        chk("dump_in_ready", 32'(m_if.in_ready), 32'd0);
        clear_exp();
        drain(1'b0);
        check_hist();
        chk("empty_total", 32'(m_if.total_count), 32'd0);

        // Accumulate two codes; last valid coincides with finish
        m_if.finish = 1'b0;
        do_reset();
        wait_clear(n);
        chk("clear_len2", 32'(n), 32'd256);
        send(7'd10, 7'd10, 8'h3C);
        send(7'd10, 7'd11, 8'h3C);
        send(7'd20, 7'd30, 8'h3C);
        send(7'd64, 7'd64, 8'h3C);
        send(7'd126, 7'd126, 8'h3C);
        send(7'd1, 7'd1, 8'hFF);
        send(7'd50, 7'd60, 8'hFF);
        m_if.finish = 1'b1;
        send(7'd100, 7'd2, 8'hFF);
        m_if.lbp_valid = 1'b0;
        chk("acc_total", 32'(m_if.total_count), 32'd8);
        clear_exp();
        exp_h[8'h3C] = 5;
        exp_h[8'hFF] = 3;
        drain(1'b0);
        check_hist();
        chk("acc_err", 32'(m_if.err), 32'd0);

        // Valid during CLEAR, border filter, random backpressure
        m_if.finish = 1'b0;
        do_reset();
        send(7'd5, 7'd5, 8'h01);
        m_if.lbp_valid = 1'b0;
        chk("clear_err", 32'(m_if.err), 32'd1);
        wait_clear(n);
        chk("clear_len3", 32'(n), 32'd255);
        send(7'd0, 7'd5, 8'h01);
        send(7'd127, 7'd5, 8'h01);
        send(7'd5, 7'd0, 8'h01);
        send(7'd5, 7'd127, 8'h01);
        send(7'd5, 7'd5, 8'h01);
        m_if.lbp_valid = 1'b0;
        m_if.finish = 1'b1;
        tick();
        clear_exp();
        exp_h[1] = 1;
        drain(1'b1);
        check_hist();
        chk("border_total", 32'(m_if.total_count), 32'd1);
        chk("err_sticky", 32'(m_if.err), 32'd1);

        // Reset in the middle of the drain, then a fresh image
        m_if.finish = 1'b0;
        do_reset();
        wait_clear(n);
        send(7'd9, 7'd9, 8'h10);
        send(7'd9, 7'd10, 8'h10);
        m_if.lbp_valid = 1'b0;
        m_if.finish = 1'b1;
        tick();
        m_if.hist_ready = 1'b1;
        cyc = 0;
        while (m_if.hist_bin != 8'd100 && cyc < 400) begin
            tick();
            cyc++;
        end
        chk("mid_bin", 32'(m_if.hist_bin), 32'd100);
        chk("mid_hv", 32'(m_if.hist_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_hv", 32'(m_if.hist_valid), 32'd0);
        chk("mid_rst_bin", 32'(m_if.hist_bin), 32'd0);
        chk("mid_rst_total", 32'(m_if.total_count), 32'd0);
        chk("mid_rst_done", 32'(m_if.done), 32'd0);
        m_if.hist_ready = 1'b0;
        m_if.finish = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        wait_clear(n);
        chk("clear_len4", 32'(n), 32'd256);
        send(7'd30, 7'd40, 8'h20);
        send(7'd30, 7'd41, 8'h20);
        send(7'd31, 7'd40, 8'h20);
        m_if.lbp_valid = 1'b0;
        m_if.finish = 1'b1;
        tick();
        clear_exp();
        exp_h[8'h20] = 3;
        drain(1'b1);
        check_hist();
        chk("mid_next_total", 32'(m_if.total_count), 32'd3);

        // finish already high when ACCUM is entered
        do_reset();
        wait_clear(n);
        chk("clear_len5", 32'(n), 32'd256);
        tick();
        chk("early_dump_hv", 32'(m_if.hist_valid), 32'd1);
        chk("early_dump_rdy", 32'(m_if.in_ready), 32'd0);

        // Saturation with 4-bit counters
        m_if.finish = 1'b0;
        do_reset();
        wait_clear(n);
        chk("sat_in_ready", 32'(s_if.in_ready), 32'd1);
        for (int i = 0; i < 20; i++) begin
            s_if.lbp_valid = 1'b1;
            s_if.lbp_addr  = {7'(i + 1), 7'd3};
            s_if.lbp_data  = 8'h07;
            tick();
        end
        s_if.lbp_valid = 1'b0;
        s_if.finish = 1'b1;
        s_if.hist_ready = 1'b1;
        sc = -1;
        cyc = 0;
        while (!s_if.done && cyc < 1000) begin
            if (s_if.hist_valid && s_if.hist_bin == 8'h07) sc = int'(s_if.hist_count);
            tick();
            cyc++;
        end
        chk("sat_bin", 32'(sc), 32'd15);
        chk("sat_total", 32'(s_if.total_count), 32'd15);
        chk("sat_done", 32'(s_if.done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
